// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-ready stall with timeout, sticky error state.
module multi_cycle_control #(
  parameter int ALUOP_W     = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MIO_ready,
  output logic               CPU_MIO,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Reverse,
  output logic [1:0]         PCSource,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         EXTOp,
  output logic [2:0]         State,
  output logic [1:0]         Err,
  output logic               InstrDone
);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALUOP_NOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALUOP_SRL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALUOP_LUI = ALUOP_W'(7);

  localparam logic [1:0] EXT_LOGIC = 2'b00;
  localparam logic [1:0] EXT_ARITH = 2'b01;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  state_t        state;
  logic [1:0]    err;
  logic [CW-1:0] cnt;

  logic unused_zero;
  assign unused_zero = Zero;

  logic is_r, r_alu, is_srl, is_jr, is_jalr;
  logic i_alu, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal, legal, waiting, tmo;

  assign is_r    = (Op == 6'h00);
  assign r_alu   = is_r && (Funct inside
                   {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h02});
  assign is_srl  = is_r && (Funct == 6'h02);
  assign is_jr   = is_r && (Funct == 6'h08);
  assign is_jalr = is_r && (Funct == 6'h09);
  assign i_alu   = Op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
  assign is_lw   = (Op == 6'h23);
  assign is_sw   = (Op == 6'h2B);
  assign is_beq  = (Op == 6'h04);
  assign is_bne  = (Op == 6'h05);
  assign is_j    = (Op == 6'h02);
  assign is_jal  = (Op == 6'h03);
  assign legal   = r_alu | is_jr | is_jalr | i_alu | is_lw | is_sw |
                   is_beq | is_bne | is_j | is_jal;

  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !MIO_ready;
  assign tmo     = (MEM_TIMEOUT > 0) && waiting && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      err   <= 2'b00;
      cnt   <= '0;
    end else begin
      cnt <= waiting ? cnt + 1'b1 : '0;
      unique case (state)
        S_FETCH: begin
          if (MIO_ready) state <= S_DECODE;
          else if (tmo) begin
            state <= S_ERROR;
            err   <= 2'b10;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            state <= S_ERROR;
            err   <= 2'b01;
          end else state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_lw || is_sw) state <= S_MEM;
          else if (r_alu || i_alu) state <= S_WB;
          else state <= S_FETCH;
        end
        S_MEM: begin
          if (MIO_ready) state <= is_lw ? S_WB : S_FETCH;
          else if (tmo) begin
            state <= S_ERROR;
            err   <= 2'b10;
          end
        end
        S_WB:    state <= S_FETCH;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

  logic [ALUOP_W-1:0] r_op, i_op;
  logic [1:0]         i_ext;

  always_comb begin
    r_op = ALUOP_ADD;
    unique case (Funct)
      6'h22:   r_op = ALUOP_SUB;
      6'h24:   r_op = ALUOP_AND;
      6'h25:   r_op = ALUOP_OR;
      6'h27:   r_op = ALUOP_NOR;
      6'h2A:   r_op = ALUOP_SLT;
      6'h02:   r_op = ALUOP_SRL;
      default: r_op = ALUOP_ADD;
    endcase
    i_op  = ALUOP_ADD;
    i_ext = EXT_ARITH;
    unique case (Op)
      6'h0A:   i_op = ALUOP_SLT;
      6'h0C:   begin i_op = ALUOP_AND; i_ext = EXT_LOGIC; end
      6'h0D:   begin i_op = ALUOP_OR;  i_ext = EXT_LOGIC; end
      6'h0F:   begin i_op = ALUOP_LUI; i_ext = EXT_LOGIC; end
      default: ;
    endcase
  end

  always_comb begin
    CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IorD = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0;
    PCWriteCond = 1'b0; Reverse = 1'b0; RegWrite = 1'b0;
    PCSource = 2'b00; RegDst = 2'b00; MemtoReg = 2'b00;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; EXTOp = 2'b00;
    ALUOp = ALUOP_ADD; InstrDone = 1'b0;
    unique case (state)
      S_FETCH: begin
        CPU_MIO = 1'b1;
        MemRead = 1'b1;
        if (MIO_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        EXTOp   = EXT_ARITH;
      end
      S_EXEC: begin
        unique case (1'b1)
          r_alu: begin
            ALUSrcA = is_srl ? 2'b10 : 2'b01;
            ALUOp   = r_op;
          end
          i_alu: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ALUOp   = i_op;
            EXTOp   = i_ext;
          end
          is_lw | is_sw: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            EXTOp   = EXT_ARITH;
          end
          is_beq | is_bne: begin
            ALUSrcA     = 2'b01;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            Reverse     = is_bne;
            InstrDone   = 1'b1;
          end
          is_j | is_jal | is_jr | is_jalr: begin
            PCWrite   = 1'b1;
            PCSource  = (is_j | is_jal) ? 2'b10 : 2'b11;
            InstrDone = 1'b1;
            if (is_jal | is_jalr) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        CPU_MIO   = 1'b1;
        IorD      = 1'b1;
        MemRead   = is_lw;
        MemWrite  = is_sw;
        InstrDone = is_sw & MIO_ready;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        RegDst    = r_alu ? 2'b00 : 2'b01;
        MemtoReg  = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign State = state;
  assign Err   = err;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-instruction sequencing,
// memory stalls, illegal-op and timeout errors.
module tb_multi_cycle_control;

  logic clk, rst_n, Zero, MIO_ready;
  logic [5:0] Op, Funct;

  logic CPU_MIO, MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic PCWriteCond, Reverse, RegWrite, InstrDone;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB, EXTOp, Err;
  logic [5:0] ALUOp;
  logic [2:0] State;

  logic z_mio, z_mr, z_mw, z_iord, z_irw, z_pcw;
  logic z_pcwc, z_rev, z_rw, z_done;
  logic [1:0] z_pcs, z_rd, z_m2r, z_sa, z_sb, z_ext, z_err;
  logic [5:0] z_aluop;
  logic [2:0] z_state;

  int vec = 0;
  int miss = 0;

  localparam logic [5:0] A_ADD = 6'd0, A_SUB = 6'd1, A_OR = 6'd3;
  localparam logic [5:0] A_SLT = 6'd5, A_SRL = 6'd6;

  wire [8:0] strb = {CPU_MIO, MemRead, MemWrite, IorD, IRWrite,
                     PCWrite, PCWriteCond, Reverse, RegWrite};
  wire [17:0] sels = {PCSource, RegDst, MemtoReg, ALUSrcA,
                      ALUSrcB, EXTOp, ALUOp};

  multi_cycle_control #(.ALUOP_W(6), .MEM_TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MIO_ready(MIO_ready), .CPU_MIO(CPU_MIO), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Reverse(Reverse),
    .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .State(State), .Err(Err),
    .InstrDone(InstrDone)
  );

  multi_cycle_control #(.ALUOP_W(6), .MEM_TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MIO_ready(MIO_ready), .CPU_MIO(z_mio), .MemRead(z_mr),
    .MemWrite(z_mw), .IorD(z_iord), .IRWrite(z_irw),
    .PCWrite(z_pcw), .PCWriteCond(z_pcwc), .Reverse(z_rev),
    .PCSource(z_pcs), .RegDst(z_rd), .MemtoReg(z_m2r),
    .RegWrite(z_rw), .ALUSrcA(z_sa), .ALUSrcB(z_sb),
    .ALUOp(z_aluop), .EXTOp(z_ext), .State(z_state), .Err(z_err),
    .InstrDone(z_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    MIO_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    Op = 6'h3F; Funct = 6'h3F;
    do_reset();
    #1;
    vec++;
    if ({State, Err} !== 5'b000_00) begin
      miss++;
      $display("FAIL reset_state got %b want 00000", {State, Err});
    end
    vec++;
    if ({strb, sels, InstrDone} !== {9'b110000000, 18'd0, 1'b0}) begin
      miss++;
      $display("FAIL reset_outs got %h %h want 180 0", strb, sels);
    end
  endtask

  task automatic test_add;
    logic [2:0] exp_s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    int done = 0;
    do_reset();
    Op = 6'h00; Funct = 6'h20; MIO_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      vec++;
      if (State !== exp_s[c]) begin
        miss++;
        $display("FAIL add_state%0d got %0d want %0d", c, State, exp_s[c]);
      end
      if (c == 0) begin
        vec++;
        if ({IRWrite, PCWrite, ALUSrcB} !== 4'b1101) begin
          miss++;
          $display("FAIL add_fetch got %b want 1101",
                   {IRWrite, PCWrite, ALUSrcB});
        end
      end
      if (c == 3) begin
        vec++;
        if ({RegWrite, RegDst, MemtoReg} !== 5'b1_00_00) begin
          miss++;
          $display("FAIL add_wb got %b want 10000",
                   {RegWrite, RegDst, MemtoReg});
        end
      end
      done += int'(InstrDone);
      tick();
    end
    vec++;
    if (done != 1) begin
      miss++;
      $display("FAIL add_done_pulses got %0d want 1", done);
    end
  endtask

  task automatic test_lw_wait;
    int n = 0;
    int memc = 0;
    do_reset();
    Op = 6'h23; Funct = 6'h00;
    for (int c = 0; c < 20; c++) begin
      if (State == 3'd3) begin
        MIO_ready = (memc == 3);
        #1;
        memc++;
        vec++;
        if ({CPU_MIO, MemRead, MemWrite, IorD} !== 4'b1101) begin
          miss++;
          $display("FAIL lw_mem got %b want 1101",
                   {CPU_MIO, MemRead, MemWrite, IorD});
        end
      end else begin
        MIO_ready = 1'b1;
        #1;
      end
      if (State == 3'd4) begin
        vec++;
        if ({RegWrite, RegDst, MemtoReg} !== 5'b1_01_01) begin
          miss++;
          $display("FAIL lw_wb got %b want 10101",
                   {RegWrite, RegDst, MemtoReg});
        end
      end
      n++;
      if (InstrDone) break;
      tick();
    end
    vec++;
    if ({n, memc} !== {32'd8, 32'd4}) begin
      miss++;
      $display("FAIL lw_cycles got %0d/%0d want 8/4", n, memc);
    end
  endtask

  task automatic test_sw;
    do_reset();
    Op = 6'h2B; Funct = 6'h00; MIO_ready = 1'b1;
    tick(); tick(); tick();
    vec++;
    if ({State, MemWrite, MemRead, InstrDone} !== 6'b011_101) begin
      miss++;
      $display("FAIL sw_mem got %b want 011101",
               {State, MemWrite, MemRead, InstrDone});
    end
    tick();
    vec++;
    if (State !== 3'd0) begin
      miss++;
      $display("FAIL sw_ret got %0d want 0", State);
    end
  endtask

  task automatic test_branch;
    logic [5:0] ops [2] = '{6'h05, 6'h04};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      Op = ops[i]; Funct = 6'h00; MIO_ready = 1'b1;
      tick(); tick();
      vec++;
      if ({State, PCWriteCond, Reverse, PCSource, ALUOp, InstrDone}
          !== {3'd2, 1'b1, (i == 0), 2'b01, A_SUB, 1'b1}) begin
        miss++;
        $display("FAIL br%0d_exec got %b %b %b %h", i, State,
                 Reverse, PCSource, ALUOp);
      end
      tick();
      vec++;
      if (State !== 3'd0) begin
        miss++;
        $display("FAIL br%0d_ret got %0d want 0", i, State);
      end
    end
  endtask

  task automatic test_jumps;
    logic [5:0] ops [4] = '{6'h02, 6'h03, 6'h00, 6'h00};
    logic [5:0] fns [4] = '{6'h00, 6'h00, 6'h08, 6'h09};
    logic [1:0] pcs [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic       lnk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      Op = ops[i]; Funct = fns[i]; MIO_ready = 1'b1;
      tick(); tick();
      vec++;
      if ({State, PCWrite, RegWrite, RegDst, MemtoReg, PCSource, InstrDone}
          !== {3'd2, 1'b1, lnk[i], {lnk[i], 1'b0}, {lnk[i], 1'b0},
               pcs[i], 1'b1}) begin
        miss++;
        $display("FAIL jmp%0d_exec got %b %b %b %b %b", i, PCWrite,
                 RegWrite, RegDst, MemtoReg, PCSource);
      end
      tick();
      vec++;
      if (State !== 3'd0) begin
        miss++;
        $display("FAIL jmp%0d_ret got %0d want 0", i, State);
      end
    end
  endtask

  task automatic test_alu;
    logic [5:0] ops [4] = '{6'h0D, 6'h0A, 6'h00, 6'h00};
    logic [5:0] fns [4] = '{6'h00, 6'h00, 6'h02, 6'h22};
    logic [5:0] aop [4] = '{A_OR, A_SLT, A_SRL, A_SUB};
    logic [1:0] ext [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0] sa  [4] = '{2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] sb  [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] rd  [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      Op = ops[i]; Funct = fns[i]; MIO_ready = 1'b1;
      tick(); tick();
      vec++;
      if ({State, ALUOp, EXTOp, ALUSrcA, ALUSrcB}
          !== {3'd2, aop[i], ext[i], sa[i], sb[i]}) begin
        miss++;
        $display("FAIL alu%0d_exec got %h %b %b %b", i, ALUOp,
                 EXTOp, ALUSrcA, ALUSrcB);
      end
      tick();
      vec++;
      if ({State, RegWrite, RegDst, InstrDone}
          !== {3'd4, 1'b1, rd[i], 1'b1}) begin
        miss++;
        $display("FAIL alu%0d_wb got %0d %b want 4 %b", i, State,
                 RegDst, rd[i]);
      end
    end
  endtask

  task automatic test_illegal;
    int bad = 0;
    do_reset();
    Op = 6'h3F; Funct = 6'h00; MIO_ready = 1'b1;
    tick(); tick();
    vec++;
    if ({State, Err} !== 5'b111_01) begin
      miss++;
      $display("FAIL ill_enter got %0d/%b want 7/01", State, Err);
    end
    for (int c = 0; c < 20; c++) begin
      if ({State, Err, strb, sels, InstrDone} !== {5'b111_01, 28'd0})
        bad++;
      tick();
    end
    vec++;
    if (bad != 0) begin
      miss++;
      $display("FAIL ill_hold got %0d bad cycles want 0", bad);
    end
    Op = 6'h00; Funct = 6'h3F;
    do_reset();
    #1;
    vec++;
    if ({State, Err, CPU_MIO} !== 6'b000_00_1) begin
      miss++;
      $display("FAIL ill_reset got %0d/%b want 0/00", State, Err);
    end
    MIO_ready = 1'b1;
    tick(); tick();
    vec++;
    if ({State, Err} !== 5'b111_01) begin
      miss++;
      $display("FAIL ill_funct got %0d/%b want 7/01", State, Err);
    end
  endtask

  task automatic test_timeout;
    int c = 0;
    do_reset();
    Op = 6'h00; Funct = 6'h20; MIO_ready = 1'b0;
    #1;
    while (State !== 3'd7 && c < 40) begin
      tick();
      c++;
    end
    vec++;
    if ({c, Err, CPU_MIO} !== {32'd16, 2'b10, 1'b0}) begin
      miss++;
      $display("FAIL tmo_enter got %0d/%b want 16/10", c, Err);
    end
    repeat (40) tick();
    vec++;
    if ({State, Err, z_state, z_err, z_mio} !== 11'b111_10_000_00_1) begin
      miss++;
      $display("FAIL tmo_nolimit got %0d/%0d want 7/0", State, z_state);
    end
    do_reset();
    repeat (15) tick();
    MIO_ready = 1'b1;
    #1;
    vec++;
    if ({State, IRWrite} !== 4'b000_1) begin
      miss++;
      $display("FAIL tmo_edge_fetch got %0d/%b want 0/1", State, IRWrite);
    end
    tick();
    vec++;
    if ({State, Err} !== 5'b001_00) begin
      miss++;
      $display("FAIL tmo_edge_dec got %0d/%b want 1/00", State, Err);
    end
  endtask

  initial begin
    rst_n = 1'b0; Zero = 1'b0; MIO_ready = 1'b0;
    Op = 6'h00; Funct = 6'h00;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jumps();
    test_alu();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle control unit for the MIPS datapath, generalised from the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and issues per-state datapath strobes instead of one combinational word. It stalls on the memory-ready handshake, with a parametrised timeout. It flags illegal instructions and memory timeouts through a sticky error state.

## Interface
- ALUOP_W, 6: width of ALUOp; codes come from the shared ALUOP_* definitions.
- MEM_TIMEOUT, 15: maximum wait cycles with MIO_ready low before a timeout error; 0 disables the timeout.
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- Op, Funct  in  6 each  IR[31:26], IR[5:0] (IR latched by datapath on IRWrite).
- Zero  in  1  ALU zero flag (used only for documentation/observability; branch resolution is done by the datapath through PCWriteCond and Reverse).
- MIO_ready  in  1  memory/IO access complete this cycle.
- CPU_MIO  out  1  memory/IO access request, held until MIO_ready.
- MemRead, MemWrite, IorD  out  1 each  read/write strobes; IorD: 0 = address from PC, 1 = address from ALUOut.
- IRWrite, PCWrite, PCWriteCond, Reverse  out  1 each  IR load; unconditional PC load; conditional PC load; invert Zero (bne).
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],addr,00}, 11 rs.
- RegDst  out  2  00 rd, 01 rt, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  ALUOP_W  ALU operation.
- EXTOp  out  2  LogicEXT / ArithmeticEXT.
- State  out  3  current state code.
- Err  out  2  00 none, 01 illegal instruction, 10 memory timeout.
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction.

## Operation
- Supported instructions (hex opcode/funct):
  - R (op 00): add 20, sub 22, and 24, or 25, nor 27, slt 2A, srl 02, jr 08, jalr 09.
  - addi 08, slti 0A, andi 0C, ori 0D, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7.
- All strobes default to 0 and all selects default to 00 in every state unless listed below.
- FETCH: CPU_MIO=1, MemRead=1, IorD=0. When MIO_ready=1:
  - IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - Next state DECODE; otherwise remain in FETCH.
- DECODE: ALUSrcA=00, ALUSrcB=11, EXTOp=Arith, ALUOp=ADD (branch target into ALUOut).
  - Illegal Op or Funct -> ERROR with Err=01.
  - Otherwise -> EXEC.
- EXEC, by class:
  - R-ALU: ALUSrcA=01 (10 for srl), ALUSrcB=00, ALUOp per funct. -> WB.
  - I-ALU: ALUSrcA=01, ALUSrcB=10. ALUOp/EXTOp: addi ADD/Arith, slti SLT/Arith, andi AND/Logic, ori OR/Logic, lui LUI/Logic. -> WB.
  - lw/sw: ALUSrcA=01, ALUSrcB=10, ALUOp=ADD, EXTOp=Arith. -> MEM.
  - beq/bne: ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, Reverse=1 for bne only. -> FETCH, InstrDone=1.
  - j: PCWrite=1, PCSource=10.
  - jal: as j, plus RegWrite=1, RegDst=10, MemtoReg=10.
  - jr: PCWrite=1, PCSource=11.
  - jalr: as jr, plus RegWrite=1, RegDst=10, MemtoReg=10.
  - All jumps -> FETCH with InstrDone=1.
- MEM: CPU_MIO=1, IorD=1; MemRead=1 for lw, MemWrite=1 for sw. On MIO_ready:
  - lw -> WB.
  - sw -> FETCH with InstrDone=1.
- WB: RegWrite=1, InstrDone=1, -> FETCH.
  - R: RegDst=00, MemtoReg=00.
  - I-ALU: RegDst=01, MemtoReg=00.
  - lw: RegDst=01, MemtoReg=01.
- Wait counter (width clog2(MEM_TIMEOUT+1), minimum 1 bit):
  - Clears on entry to FETCH or MEM and on any MIO_ready=1.
  - Increments each cycle in FETCH/MEM while MIO_ready=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with MIO_ready still 0 -> ERROR with Err=10.
  - MIO_ready=1 in the same cycle the limit is reached: the access completes normally and no error is raised.
- ERROR: all strobes 0, including CPU_MIO. Sticky until rst_n=0; Err holds its value.

## Timing
- Reset (rst_n=0 at a clk edge): State=FETCH, Err=00, counter=0.
  - Outputs in FETCH with zero wait: CPU_MIO=1, MemRead=1; every other strobe 0.
  - Reset overrides any in-progress access or error.
- Outputs are Moore-decoded from State and IR fields. The exceptions, qualified combinationally by MIO_ready, are IRWrite, PCWrite and the ALU selects in FETCH, and the state transitions out of FETCH/MEM.
- Latency with zero-wait memory:
  - branch/jump: 3 cycles.
  - R, I-ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Op/Funct are sampled only in DECODE/EXEC/MEM/WB (IR stable); FETCH ignores them.

## Test plan
- Reset, then add (Op=00, Funct=20) with MIO_ready=1 constantly: states 0,1,2,4,0; in WB RegWrite=1, RegDst=00; InstrDone high for exactly 1 cycle.
- lw with MIO_ready low 3 cycles in MEM: State stays 3 for 4 cycles, MemRead/CPU_MIO held throughout; WB has MemtoReg=01; total 8 cycles.
- bne (Op=05): EXEC has PCWriteCond=1, Reverse=1, PCSource=01, ALUOp=SUB; beq gives Reverse=0; both 3 cycles.
- jal and jalr: EXEC has PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10; PCSource=10 for jal, 11 for jalr.
- Op=3F: DECODE -> ERROR (State=7), Err=01, all strobes 0, held for 20 cycles; rst_n=0 returns State=0, Err=00.
- MEM_TIMEOUT=15, MIO_ready never asserted in FETCH: ERROR entered after 15 waiting cycles, Err=10. Repeat with MIO_ready=1 on the limit cycle: no error, DECODE entered. MEM_TIMEOUT=0: waits indefinitely.
